gat_bram_loader: RTL
====================

GAT_BRAM_LOADER -- requirements
Module: gat_bram_loader

Interface
REQ-001 SHALL have parameter TOP_WIDTH, default 32: width of the host word and of the BRAM din buses.
REQ-002 SHALL have parameter H_DATA_DEPTH, default 242101: number of words in the H sparse-data section.
REQ-003 SHALL have parameter NODE_INFO_DEPTH, default 13264: number of words in the H node-info section.
REQ-004 SHALL have parameter WEIGHT_DEPTH, default 22928: number of words in the weight section.
REQ-005 SHALL have parameter ADDR_W, default 20: width of each byte-address output.
REQ-006 SHALL use one clock and a synchronous, active-high reset, with ports named as follows.
REQ-007 clk  input  1  sole clock; all logic on the rising edge.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 start  input  1  single-cycle pulse that begins a load sequence.
REQ-010 s_valid / s_ready  input / output  1 / 1  host word handshake; a word transfers when both are high.
REQ-011 s_data  input  TOP_WIDTH  host word.
REQ-012 s_last  input  1  marks the final word of the current section.
REQ-013 h_data_bram_din, h_node_info_bram_din, wgt_bram_din  output  TOP_WIDTH each  BRAM write data.
REQ-014 *_ena, *_wea  output  1 each (three ports each)  BRAM enable and write enable.
REQ-015 *_addra  output  ADDR_W each (three ports)  BRAM byte address.
REQ-016 h_data_bram_load_done, h_node_info_bram_load_done, wgt_bram_load_done  output  1 each  sticky per-section completion flags.
REQ-017 busy  output  1  high while in any LOAD state.
REQ-018 err  output  1  sticky framing error.
REQ-019 checksum  output  32  running checksum of accepted words (see Configuration).

Function
REQ-020 FSM states SHALL be IDLE, LOAD_H, LOAD_INFO, LOAD_WGT, DONE and ERR.
REQ-021 start in IDLE or DONE SHALL clear all done flags, err, the word counter and the checksum, and go to LOAD_H.
REQ-022 start in LOAD_* or ERR SHALL be ignored.
REQ-023 s_ready SHALL equal 1 exactly in the LOAD_* states.
REQ-024 Each accepted word SHALL be written to the BRAM of the current section only.
REQ-025 The write SHALL be a single-cycle ena=wea=1 pulse, one cycle after the handshake (registered outputs).
REQ-026 Write address SHALL be addra = word_index*4, in bytes.
REQ-027 word_index SHALL start at 0 per section and increment by 1 per accepted word.
REQ-028 addra SHALL be truncated to ADDR_W bits with no saturation.
REQ-029 din SHALL equal s_data, registered.
REQ-030 Outside a write pulse, ena/wea SHALL be 0; din and addra SHALL hold their last values.
REQ-031 When a section's final word is accepted (word_index == DEPTH-1), its load_done SHALL go to 1 in the same cycle as that word's write pulse.
REQ-032 On that final word, word_index SHALL reset to 0 and the FSM SHALL advance LOAD_H -> LOAD_INFO -> LOAD_WGT -> DONE.
REQ-033 load_done flags SHALL stay 1 until the next accepted start or rst.
REQ-034 s_last high on a non-final word, or low on a final word, SHALL still perform the write.
REQ-035 In that mismatch case the block SHALL then set err and go to ERR; err SHALL stay 1 until start from DONE is impossible, so it clears only on rst.
REQ-036 In ERR, s_ready SHALL be 0 and no writes or done flags SHALL be issued.
REQ-037 s_valid while s_ready=0 SHALL NOT be consumed.
REQ-038 Back-to-back handshakes SHALL sustain 1 word/cycle.
REQ-039 busy SHALL be 1 exactly in the LOAD_* states.

Reset
REQ-040 rst SHALL force state IDLE and clear word_index and checksum.
REQ-041 After rst, all outputs SHALL be 0, including mid-load and in the cycle after a pending handshake.
REQ-042 A write pending at rst SHALL be dropped.

Configuration
REQ-043 Macro GAT_LOADER_CHECKSUM_EN defined: checksum SHALL be the modulo-2^32 sum of every accepted s_data.
REQ-044 The checksum SHALL update one cycle after the handshake, with zero extension when TOP_WIDTH<32.
REQ-045 Macro GAT_LOADER_CHECKSUM_EN undefined: checksum SHALL be constant 0 and the accumulator SHALL not exist.

Verification
REQ-046 Depths 4/3/2, start, then 9 contiguous valid words with correct s_last -> correct writes and flags:
- h addra 0,4,8,12; info 0,4,8; wgt 0,4.
- Each done flag rises with its last write pulse; DONE in the cycle after the 9th handshake; busy then 0.
REQ-047 Same stream with s_valid toggling every other cycle -> identical BRAM contents and addresses; no word lost or duplicated.
REQ-048 s_last asserted on the 2nd h word -> that word is written at addra 4, err=1, s_ready=0 thereafter, all done flags 0.
REQ-049 rst pulsed after 2 info words -> next cycle state IDLE, all outputs 0; restart loads h from addra 0.
REQ-050 With the macro defined, words 0xFFFFFFFF, 0x00000002 -> checksum 0x00000001; without the macro -> checksum 0.
REQ-051 start during LOAD_INFO -> ignored, with counters and flags unchanged.
REQ-052 start in DONE -> flags cleared, load restarts at LOAD_H.

Source files
------------

// File: rtl/gat_bram_loader.sv
// Streams host words into the H-data, H-node-info and weight BRAMs in that order.
// Optional running checksum of accepted words: define GAT_LOADER_CHECKSUM_EN.
module gat_bram_loader #(
    parameter int unsigned TOP_WIDTH       = 32,
    parameter int unsigned H_DATA_DEPTH    = 242101,
    parameter int unsigned NODE_INFO_DEPTH = 13264,
    parameter int unsigned WEIGHT_DEPTH    = 22928,
    parameter int unsigned ADDR_W          = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [TOP_WIDTH-1:0] s_data,
    input  logic                 s_last,
    output logic [TOP_WIDTH-1:0] h_data_bram_din,
    output logic                 h_data_bram_ena,
    output logic                 h_data_bram_wea,
    output logic [ADDR_W-1:0]    h_data_bram_addra,
    output logic [TOP_WIDTH-1:0] h_node_info_bram_din,
    output logic                 h_node_info_bram_ena,
    output logic                 h_node_info_bram_wea,
    output logic [ADDR_W-1:0]    h_node_info_bram_addra,
    output logic [TOP_WIDTH-1:0] wgt_bram_din,
    output logic                 wgt_bram_ena,
    output logic                 wgt_bram_wea,
    output logic [ADDR_W-1:0]    wgt_bram_addra,
    output logic                 h_data_bram_load_done,
    output logic                 h_node_info_bram_load_done,
    output logic                 wgt_bram_load_done,
    output logic                 busy,
    output logic                 err,
    output logic [31:0]          checksum
);

    localparam int unsigned MAX_DEPTH_HI = (H_DATA_DEPTH > NODE_INFO_DEPTH) ? H_DATA_DEPTH : NODE_INFO_DEPTH;
    localparam int unsigned MAX_DEPTH    = (MAX_DEPTH_HI > WEIGHT_DEPTH) ? MAX_DEPTH_HI : WEIGHT_DEPTH;
    localparam int unsigned IDX_W        = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_H,
        S_LOAD_INFO,
        S_LOAD_WGT,
        S_DONE,
        S_ERR
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   word_index;
    logic               fire_c;
    logic               final_c;
    logic               restart_c;
    logic               mismatch_c;
    logic               load_next_c;
    logic [ADDR_W-1:0]  addr_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus the handshake qualifiers the datapath consumes.
    always_comb begin
        state_next = state;
        fire_c     = s_valid && s_ready;
        final_c    = 1'b0;
        restart_c  = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    restart_c  = 1'b1;
                    state_next = S_LOAD_H;
                end
            end
            S_LOAD_H: begin
                final_c = (word_index == IDX_W'(H_DATA_DEPTH - 1));
                if (fire_c) begin
                    if (s_last != final_c) state_next = S_ERR;
                    else if (final_c)      state_next = S_LOAD_INFO;
                end
            end
            S_LOAD_INFO: begin
                final_c = (word_index == IDX_W'(NODE_INFO_DEPTH - 1));
                if (fire_c) begin
                    if (s_last != final_c) state_next = S_ERR;
                    else if (final_c)      state_next = S_LOAD_WGT;
                end
            end
            S_LOAD_WGT: begin
                final_c = (word_index == IDX_W'(WEIGHT_DEPTH - 1));
                if (fire_c) begin
                    if (s_last != final_c) state_next = S_ERR;
                    else if (final_c)      state_next = S_DONE;
                end
            end
            S_ERR:   state_next = S_ERR;
            default: state_next = S_IDLE;
        endcase
        mismatch_c  = fire_c && (s_last != final_c);
        load_next_c = (state_next == S_LOAD_H) || (state_next == S_LOAD_INFO) ||
                      (state_next == S_LOAD_WGT);
        addr_c      = ADDR_W'({word_index, 2'b00});
    end

    // Registered BRAM write ports, flags and handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_index                 <= '0;
            s_ready                    <= 1'b0;
            busy                       <= 1'b0;
            err                        <= 1'b0;
            h_data_bram_din            <= '0;
            h_data_bram_ena            <= 1'b0;
            h_data_bram_wea            <= 1'b0;
            h_data_bram_addra          <= '0;
            h_node_info_bram_din       <= '0;
            h_node_info_bram_ena       <= 1'b0;
            h_node_info_bram_wea       <= 1'b0;
            h_node_info_bram_addra     <= '0;
            wgt_bram_din               <= '0;
            wgt_bram_ena               <= 1'b0;
            wgt_bram_wea               <= 1'b0;
            wgt_bram_addra             <= '0;
            h_data_bram_load_done      <= 1'b0;
            h_node_info_bram_load_done <= 1'b0;
            wgt_bram_load_done         <= 1'b0;
        end else begin
            s_ready              <= load_next_c;
            busy                 <= load_next_c;
            h_data_bram_ena      <= 1'b0;
            h_data_bram_wea      <= 1'b0;
            h_node_info_bram_ena <= 1'b0;
            h_node_info_bram_wea <= 1'b0;
            wgt_bram_ena         <= 1'b0;
            wgt_bram_wea         <= 1'b0;
            if (restart_c) begin
                word_index                 <= '0;
                err                        <= 1'b0;
                h_data_bram_load_done      <= 1'b0;
                h_node_info_bram_load_done <= 1'b0;
                wgt_bram_load_done         <= 1'b0;
            end
            if (fire_c) begin
                word_index <= final_c ? '0 : word_index + IDX_W'(1);
                case (state)
                    S_LOAD_H: begin
                        h_data_bram_ena   <= 1'b1;
                        h_data_bram_wea   <= 1'b1;
                        h_data_bram_din   <= s_data;
                        h_data_bram_addra <= addr_c;
                        if (final_c) h_data_bram_load_done <= 1'b1;
                    end
                    S_LOAD_INFO: begin
                        h_node_info_bram_ena   <= 1'b1;
                        h_node_info_bram_wea   <= 1'b1;
                        h_node_info_bram_din   <= s_data;
                        h_node_info_bram_addra <= addr_c;
                        if (final_c) h_node_info_bram_load_done <= 1'b1;
                    end
                    S_LOAD_WGT: begin
                        wgt_bram_ena   <= 1'b1;
                        wgt_bram_wea   <= 1'b1;
                        wgt_bram_din   <= s_data;
                        wgt_bram_addra <= addr_c;
                        if (final_c) wgt_bram_load_done <= 1'b1;
                    end
                    default: ;
                endcase
            end
            if (mismatch_c) err <= 1'b1;
        end
    end

`ifdef GAT_LOADER_CHECKSUM_EN
    logic [31:0] csum;

    always_ff @(posedge clk) begin
        if (rst || restart_c) begin
            csum <= '0;
        end else if (fire_c) begin
            csum <= csum + 32'(s_data);
        end
    end

    assign checksum = csum;
`else
    assign checksum = 32'd0;
`endif

endmodule
